tr_exec_unit: RTL and testbench



---
 rtl/tr_exec_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_tr_exec_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tr_exec_unit.sv
// Time-redundant execute stage: freezes forwarded operands, runs the ALU REPS times, votes/retries, registers into EX/MEM.
// Latency: REPS cycles from accept to out_valid when fault-free, plus REPS cycles per retry.
// Backpressure: in_ready only in IDLE, or in OUT while out_ready; M outputs hold stable in OUT until out_ready.

module tr_exec_unit #(
   parameter int XLEN      = 32,
   parameter int REPS      = 2,
   parameter int MAX_RETRY = 3,
   parameter int FCNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reg_write_e,
   input  logic              mem_write_e,
   input  logic              result_src_e,
   input  logic              branch_e,
   input  logic              alu_src_e,
   input  logic [2:0]        alu_ctrl_e,
   input  logic [XLEN-1:0]   rd1_e,
   input  logic [XLEN-1:0]   rd2_e,
   input  logic [XLEN-1:0]   imm_e,
   input  logic [XLEN-1:0]   pc_e,
   input  logic [XLEN-1:0]   pc_plus4_e,
   input  logic [4:0]        rd_e,
   input  logic [1:0]        fwd_a_e,
   input  logic [1:0]        fwd_b_e,
   input  logic [XLEN-1:0]   result_w,
   input  logic [XLEN-1:0]   alu_result_fwd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              reg_write_m,
   output logic              mem_write_m,
   output logic              result_src_m,
   output logic              pc_src_m,
   output logic [4:0]        rd_m,
   output logic [XLEN-1:0]   alu_result_m,
   output logic [XLEN-1:0]   write_data_m,
   output logic [XLEN-1:0]   pc_plus4_m,
   output logic [XLEN-1:0]   pc_target_m,
   input  logic              inj_en,
   input  logic              inj_persist,
   input  logic [1:0]        inj_pass,
   input  logic [XLEN-1:0]   inj_mask,
   input  logic              flt_clr,
   output logic              fault_det,
   output logic              fault_uncorr,
   output logic [FCNT_W-1:0] fault_count
);

   localparam int              RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [1:0]      LAST_PASS   = 2'(REPS - 1);
   localparam logic [RW-1:0]   MAX_RETRY_R = RW'(MAX_RETRY);
   localparam logic [FCNT_W-1:0] FCNT_MAX  = {FCNT_W{1'b1}};

   // Only dual (compare/retry) and triple (vote) redundancy are meaningful.
   if (REPS != 2 && REPS != 3) begin : gBadReps
      $error("tr_exec_unit: REPS must be 2 or 3");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, OUT = 2'd2} state_t;

   state_t            state, stateNext;
   logic [1:0]        pass;
   logic [RW-1:0]     retry;
   logic [XLEN-1:0]   res [0:1];
   logic [XLEN-1:0]   srcA, srcB, storeData, pcPlus4L, pcTargetL;
   logic [4:0]        rdL;
   logic [2:0]        aluCtrlL;
   logic              regWriteL, memWriteL, resultSrcL, branchL;

   logic [XLEN-1:0]   fwdA, fwdB, aluOut, passVal, resolved;
   logic              injHit, disagree, unresolved;
   logic              inReady, accept, commit, doRetry, faultEv, setUncorr;

   assign in_ready = inReady;

   // Forwarding muxes feeding the operand latches.
   always_comb begin
      fwdA = rd1_e;
      fwdB = rd2_e;
      case (fwd_a_e)
         2'b01:   fwdA = result_w;
         2'b10:   fwdA = alu_result_fwd;
         default: fwdA = rd1_e;
      endcase
      case (fwd_b_e)
         2'b01:   fwdB = result_w;
         2'b10:   fwdB = alu_result_fwd;
         default: fwdB = rd2_e;
      endcase
   end

   // ALU on the frozen operands, with optional fault injection on the selected pass.
   always_comb begin
      aluOut = '0;
      case (aluCtrlL)
         3'b000:  aluOut = srcA + srcB;
         3'b001:  aluOut = srcA - srcB;
         3'b010:  aluOut = srcA & srcB;
         3'b011:  aluOut = srcA | srcB;
         3'b101:  aluOut = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
         default: aluOut = '0;
      endcase
      injHit  = inj_en && (pass == inj_pass) && ((retry == '0) || inj_persist);
      passVal = injHit ? (aluOut ^ inj_mask) : aluOut;
   end

   // Compare (dual) or majority vote (triple) of stored passes against the current one.
   always_comb begin
      resolved   = passVal;
      disagree   = 1'b0;
      unresolved = 1'b0;
      if (REPS == 3) begin
         if (res[0] == res[1] && res[0] == passVal) begin
            resolved = passVal;
         end else if (res[0] == res[1] || res[0] == passVal) begin
            resolved = res[0];
            disagree = 1'b1;
         end else if (res[1] == passVal) begin
            resolved = res[1];
            disagree = 1'b1;
         end else begin
            disagree   = 1'b1;
            unresolved = 1'b1;
         end
      end else if (res[0] != passVal) begin
         disagree   = 1'b1;
         unresolved = 1'b1;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      stateNext = state;
      inReady   = 1'b0;
      accept    = 1'b0;
      commit    = 1'b0;
      doRetry   = 1'b0;
      faultEv   = 1'b0;
      setUncorr = 1'b0;
      case (state)
         IDLE: begin
            inReady = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               stateNext = EXEC;
            end
         end
         EXEC: begin
            if (pass == LAST_PASS) begin
               faultEv = disagree;
               if (unresolved && (retry < MAX_RETRY_R)) begin
                  doRetry = 1'b1;
               end else begin
                  commit    = 1'b1;
                  setUncorr = unresolved;
                  stateNext = OUT;
               end
            end
         end
         OUT: begin
            if (out_ready) begin
               inReady = 1'b1;
               if (in_valid) begin
                  accept    = 1'b1;
                  stateNext = EXEC;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   // Operand latching, pass sequencing, EX/MEM register and fault bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass         <= '0;
         retry        <= '0;
         res[0]       <= '0;
         res[1]       <= '0;
         srcA         <= '0;
         srcB         <= '0;
         storeData    <= '0;
         pcPlus4L     <= '0;
         pcTargetL    <= '0;
         rdL          <= '0;
         aluCtrlL     <= '0;
         regWriteL    <= 1'b0;
         memWriteL    <= 1'b0;
         resultSrcL   <= 1'b0;
         branchL      <= 1'b0;
         out_valid    <= 1'b0;
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         result_src_m <= 1'b0;
         pc_src_m     <= 1'b0;
         rd_m         <= '0;
         alu_result_m <= '0;
         write_data_m <= '0;
         pc_plus4_m   <= '0;
         pc_target_m  <= '0;
         fault_det    <= 1'b0;
         fault_uncorr <= 1'b0;
         fault_count  <= '0;
      end else begin
         if (accept) begin
            srcA       <= fwdA;
            srcB       <= alu_src_e ? imm_e : fwdB;
            storeData  <= fwdB;
            pcPlus4L   <= pc_plus4_e;
            pcTargetL  <= pc_e + imm_e;
            rdL        <= rd_e;
            aluCtrlL   <= alu_ctrl_e;
            regWriteL  <= reg_write_e;
            memWriteL  <= mem_write_e;
            resultSrcL <= result_src_e;
            branchL    <= branch_e;
            pass       <= '0;
            retry      <= '0;
         end else if (state == EXEC) begin
            if (pass != LAST_PASS) begin
               res[pass[0]] <= passVal;
               pass         <= pass + 2'd1;
            end else if (doRetry) begin
               pass  <= '0;
               retry <= retry + RW'(1);
            end
         end

         if (commit) begin
            out_valid    <= 1'b1;
            alu_result_m <= resolved;
            write_data_m <= storeData;
            pc_plus4_m   <= pcPlus4L;
            pc_target_m  <= pcTargetL;
            rd_m         <= rdL;
            reg_write_m  <= regWriteL;
            mem_write_m  <= memWriteL;
            result_src_m <= resultSrcL;
            pc_src_m     <= branchL && (resolved == '0);
         end else if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
         end

         fault_det <= faultEv;
         if (flt_clr) begin
            fault_count  <= '0;
            fault_uncorr <= 1'b0;
         end else begin
            if (faultEv && fault_count != FCNT_MAX) fault_count <= fault_count + 1'b1;
            if (setUncorr) fault_uncorr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tr_exec_unit.sv
// Bench for tr_exec_unit: dual (REPS=2) and triple (REPS=3) instances driven with identical operations.
// Expected responses are queued at issue time and compared by per-instance monitors on each output handshake.
// Out_ready is normally high; selected operations stall the output to check hold behaviour.

module tb_tr_exec_unit;
   localparam int MAX_RETRY = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        inValid, outReady, regWrite, memWrite, resultSrc, branch, aluSrc;
   logic [2:0]  aluCtrl;
   logic [31:0] rd1, rd2, imm, pc, pcPlus4, resultW, aluResultFwd, injMask;
   logic [4:0]  rd;
   logic [1:0]  fwdA, fwdB, injPass;
   logic        injEn, injPersist, fltClr;

   logic        inReady2, outValid2, regWriteM2, memWriteM2, resultSrcM2, pcSrcM2, faultDet2, faultUncorr2;
   logic [4:0]  rdM2;
   logic [31:0] aluResultM2, writeDataM2, pcPlus4M2, pcTargetM2;
   logic [7:0]  faultCount2;
   logic        inReady3, outValid3, regWriteM3, memWriteM3, resultSrcM3, pcSrcM3, faultDet3, faultUncorr3;
   logic [4:0]  rdM3;
   logic [31:0] aluResultM3, writeDataM3, pcPlus4M3, pcTargetM3;
   logic [7:0]  faultCount3;

   tr_exec_unit #(.XLEN(32), .REPS(2), .MAX_RETRY(MAX_RETRY), .FCNT_W(8)) dut2 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady2),
      .reg_write_e(regWrite), .mem_write_e(memWrite), .result_src_e(resultSrc), .branch_e(branch),
      .alu_src_e(aluSrc), .alu_ctrl_e(aluCtrl), .rd1_e(rd1), .rd2_e(rd2), .imm_e(imm), .pc_e(pc),
      .pc_plus4_e(pcPlus4), .rd_e(rd), .fwd_a_e(fwdA), .fwd_b_e(fwdB), .result_w(resultW),
      .alu_result_fwd(aluResultFwd), .out_valid(outValid2), .out_ready(outReady),
      .reg_write_m(regWriteM2), .mem_write_m(memWriteM2), .result_src_m(resultSrcM2), .pc_src_m(pcSrcM2),
      .rd_m(rdM2), .alu_result_m(aluResultM2), .write_data_m(writeDataM2), .pc_plus4_m(pcPlus4M2),
      .pc_target_m(pcTargetM2), .inj_en(injEn), .inj_persist(injPersist), .inj_pass(injPass),
      .inj_mask(injMask), .flt_clr(fltClr), .fault_det(faultDet2), .fault_uncorr(faultUncorr2),
      .fault_count(faultCount2));

   tr_exec_unit #(.XLEN(32), .REPS(3), .MAX_RETRY(MAX_RETRY), .FCNT_W(8)) dut3 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady3),
      .reg_write_e(regWrite), .mem_write_e(memWrite), .result_src_e(resultSrc), .branch_e(branch),
      .alu_src_e(aluSrc), .alu_ctrl_e(aluCtrl), .rd1_e(rd1), .rd2_e(rd2), .imm_e(imm), .pc_e(pc),
      .pc_plus4_e(pcPlus4), .rd_e(rd), .fwd_a_e(fwdA), .fwd_b_e(fwdB), .result_w(resultW),
      .alu_result_fwd(aluResultFwd), .out_valid(outValid3), .out_ready(outReady),
      .reg_write_m(regWriteM3), .mem_write_m(memWriteM3), .result_src_m(resultSrcM3), .pc_src_m(pcSrcM3),
      .rd_m(rdM3), .alu_result_m(aluResultM3), .write_data_m(writeDataM3), .pc_plus4_m(pcPlus4M3),
      .pc_target_m(pcTargetM3), .inj_en(injEn), .inj_persist(injPersist), .inj_pass(injPass),
      .inj_mask(injMask), .flt_clr(fltClr), .fault_det(faultDet3), .fault_uncorr(faultUncorr3),
      .fault_count(faultCount3));

   typedef struct {
      logic [31:0] res, wd, p4, pt;
      logic [4:0]  rd;
      logic [3:0]  ctl;   // {reg_write, mem_write, result_src, pc_src}
      int          fd;
      logic [7:0]  fc;
      logic        unc;
      int          acc;
      int          lat;   // -1: not checked (stalled output)
   } exp_t;

   exp_t q2[$], q3[$];
   exp_t e2, e3;
   int   checks = 0, errors = 0, cyc = 0, fd2 = 0, fd3 = 0;
   int   fcM[2];
   logic uncM[2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic timeoutFail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no event required=event within bound", nm);
   endtask

   function automatic logic [31:0] aluRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Attempt-by-attempt outcome of the redundant execution, from the injection settings.
   function automatic void resolveRef(input int reps, input logic [31:0] good,
                                      output logic [31:0] res, output int fd, output int lat, output logic unc);
      logic [31:0] r [3];
      fd = 0; lat = 0; unc = 1'b0; res = good;
      for (int k = 0; k <= MAX_RETRY; k++) begin
         for (int p = 0; p < 3; p++)
            r[p] = (injEn && p == int'(injPass) && (k == 0 || injPersist)) ? (good ^ injMask) : good;
         lat += reps;
         if (reps == 2) begin
            if (r[0] == r[1]) begin res = r[0]; return; end
            fd++; res = r[1];
         end else begin
            if (r[0] == r[1] && r[1] == r[2]) begin res = r[0]; return; end
            if (r[0] == r[1] || r[0] == r[2]) begin res = r[0]; fd++; return; end
            if (r[1] == r[2]) begin res = r[1]; fd++; return; end
            fd++; res = r[2];
         end
      end
      unc = 1'b1;
   endfunction

   function automatic logic [31:0] fwdSel(input logic [1:0] s, input logic [31:0] reg_v);
      case (s)
         2'b01:   return resultW;
         2'b10:   return aluResultFwd;
         default: return reg_v;
      endcase
   endfunction

   task automatic checkTxn(input string tag, input exp_t e, input logic [31:0] res, input logic [31:0] wd,
                           input logic [31:0] p4, input logic [31:0] pt, input logic [4:0] rdv,
                           input logic [3:0] ctl, input int fd, input logic [7:0] fc, input logic unc);
      chk({tag, ".result"}, res, e.res);
      chk({tag, ".write_data"}, wd, e.wd);
      chk({tag, ".pc_plus4"}, p4, e.p4);
      chk({tag, ".pc_target"}, pt, e.pt);
      chk({tag, ".rd"}, rdv, e.rd);
      chk({tag, ".ctl"}, ctl, e.ctl);
      chk({tag, ".fault_det_pulses"}, fd, e.fd);
      chk({tag, ".fault_count"}, fc, e.fc);
      chk({tag, ".fault_uncorr"}, unc, e.unc);
      if (e.lat >= 0) chk({tag, ".latency"}, cyc - e.acc, e.lat);
   endtask

   // Monitors: count fault_det pulses, compare against the queue head on each output handshake.
   always @(negedge clk) begin
      if (rst) begin
         if (faultDet2) fd2++;
         if (outValid2 && outReady) begin
            if (q2.size() == 0) begin
               checks++; errors++;
               $display("FAIL r2.unexpected actual=out_valid required=no output");
            end else begin
               e2 = q2.pop_front();
               checkTxn("r2", e2, aluResultM2, writeDataM2, pcPlus4M2, pcTargetM2, rdM2,
                        {regWriteM2, memWriteM2, resultSrcM2, pcSrcM2}, fd2, faultCount2, faultUncorr2);
               fd2 = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (faultDet3) fd3++;
         if (outValid3 && outReady) begin
            if (q3.size() == 0) begin
               checks++; errors++;
               $display("FAIL r3.unexpected actual=out_valid required=no output");
            end else begin
               e3 = q3.pop_front();
               checkTxn("r3", e3, aluResultM3, writeDataM3, pcPlus4M3, pcTargetM3, rdM3,
                        {regWriteM3, memWriteM3, resultSrcM3, pcSrcM3}, fd3, faultCount3, faultUncorr3);
               fd3 = 0;
            end
         end
      end
   end

   task automatic waitDone();
      int n = 0;
      while ((q2.size() != 0 || q3.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q2.size() != 0 || q3.size() != 0) begin
         timeoutFail("done");
         q2.delete(); q3.delete();
      end
   endtask

   task automatic stallCheck();
      int n = 0;
      logic [31:0] s2, s3;
      while (!(outValid2 && outValid3) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!(outValid2 && outValid3)) begin
         timeoutFail("stall.valid");
      end else begin
         s2 = aluResultM2;
         s3 = aluResultM3;
         repeat (5) begin
            @(negedge clk);
            chk("stall.valid2", outValid2, 1);
            chk("stall.res2", aluResultM2, s2);
            chk("stall.in_ready2", inReady2, 0);
            chk("stall.valid3", outValid3, 1);
            chk("stall.res3", aluResultM3, s3);
            chk("stall.in_ready3", inReady3, 0);
         end
      end
      outReady = 1'b1;
   endtask

   // Offer the operation set up in the input variables to both instances and queue expectations.
   task automatic send(input bit stall, input bit waitEnd);
      logic [31:0] fa, fb, good, r;
      int fd, lat, n;
      logic unc;
      exp_t e;
      @(negedge clk);
      n = 0;
      while (!(inReady2 && inReady3) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!(inReady2 && inReady3)) timeoutFail("in_ready");
      fa   = fwdSel(fwdA, rd1);
      fb   = fwdSel(fwdB, rd2);
      good = aluRef(aluCtrl, fa, aluSrc ? imm : fb);
      for (int i = 0; i < 2; i++) begin
         resolveRef(i + 2, good, r, fd, lat, unc);
         if (fltClr) begin
            fcM[i]  = 0;
            uncM[i] = 1'b0;
         end else begin
            fcM[i]  = (fcM[i] + fd > 255) ? 255 : fcM[i] + fd;
            uncM[i] = uncM[i] | unc;
         end
         e.res = r;  e.wd = fb;  e.p4 = pcPlus4;  e.pt = pc + imm;  e.rd = rd;
         e.ctl = {regWrite, memWrite, resultSrc, branch && (r == 32'd0)};
         e.fd  = fd; e.fc = 8'(fcM[i]); e.unc = uncM[i];
         e.acc = cyc + 1; e.lat = stall ? -1 : lat;
         if (i == 0) q2.push_back(e);
         else        q3.push_back(e);
      end
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid      = 1'b0;
      resultW      = $urandom;
      aluResultFwd = $urandom;
      rd1          = $urandom;
      rd2          = $urandom;
      if (stall) begin
         outReady = 1'b0;
         stallCheck();
      end
      if (waitEnd) waitDone();
   endtask

   task automatic setDefaults();
      inValid = 1'b0; outReady = 1'b1;
      regWrite = 1'b0; memWrite = 1'b0; resultSrc = 1'b0; branch = 1'b0; aluSrc = 1'b0;
      aluCtrl = 3'd0; rd1 = '0; rd2 = '0; imm = '0; pc = '0; pcPlus4 = 32'd4; rd = 5'd0;
      fwdA = 2'b00; fwdB = 2'b00; resultW = '0; aluResultFwd = '0;
      injEn = 1'b0; injPersist = 1'b0; injPass = 2'd0; injMask = '0; fltClr = 1'b0;
   endtask

   task automatic checkZero(input string tag);
      chk({tag, ".out_valid2"}, outValid2, 0);
      chk({tag, ".result2"}, aluResultM2, 0);
      chk({tag, ".pc_target2"}, pcTargetM2, 0);
      chk({tag, ".ctl2"}, {regWriteM2, memWriteM2, resultSrcM2, pcSrcM2, rdM2}, 0);
      chk({tag, ".faults2"}, {faultDet2, faultUncorr2, faultCount2}, 0);
      chk({tag, ".out_valid3"}, outValid3, 0);
      chk({tag, ".result3"}, aluResultM3, 0);
      chk({tag, ".write_data3"}, writeDataM3, 0);
      chk({tag, ".faults3"}, {faultDet3, faultUncorr3, faultCount3}, 0);
   endtask

   initial begin
      setDefaults();
      fcM[0] = 0; fcM[1] = 0; uncM[0] = 1'b0; uncM[1] = 1'b0;
      #12;
      checkZero("reset");
      @(negedge clk);
      rst = 1'b1;

      // add 5+7, clean
      setDefaults(); aluCtrl = 3'd0; rd1 = 32'd5; rd2 = 32'd7; rd = 5'd3; regWrite = 1'b1;
      send(0, 1);
      // sub 10-3, pass 1 corrupted once
      setDefaults(); aluCtrl = 3'd1; rd1 = 32'd10; rd2 = 32'd3; injEn = 1'b1; injPass = 2'd1; injMask = 32'd1;
      send(0, 1);
      // same, persistent corruption: dual instance exhausts retries
      injPersist = 1'b1;
      send(0, 1);
      // and 0xF0 & 0x3C, pass 0 corrupted
      setDefaults(); aluCtrl = 3'd2; rd1 = 32'hF0; rd2 = 32'h3C; injEn = 1'b1; injPass = 2'd0; injMask = 32'h8000_0000;
      send(0, 1);
      // forwarded A from alu_result_fwd, changed after accept
      setDefaults(); fwdA = 2'b10; aluResultFwd = 32'h100; rd1 = 32'hDEAD; rd2 = 32'h20;
      send(0, 1);
      // store data forwarded from result_w, immediate B operand
      setDefaults(); fwdB = 2'b01; resultW = 32'hCAFE; aluSrc = 1'b1; imm = 32'd8; rd1 = 32'h40; memWrite = 1'b1;
      send(0, 1);
      // beq-style: equal operands, branch taken
      setDefaults(); aluCtrl = 3'd1; rd1 = 32'h55; rd2 = 32'h55; branch = 1'b1; imm = 32'h40;
      pc = 32'h1000; pcPlus4 = 32'h1004;
      send(0, 1);
      // stalled output
      setDefaults(); rd1 = 32'd1; rd2 = 32'd2; resultSrc = 1'b1;
      send(1, 1);
      // fault detected while flt_clr held
      setDefaults(); aluCtrl = 3'd1; rd1 = 32'd9; rd2 = 32'd4; injEn = 1'b1; injPass = 2'd0; injMask = 32'd4;
      fltClr = 1'b1;
      send(0, 1);
      fltClr = 1'b0;

      for (int t = 0; t < 60; t++) begin
         aluCtrl = 3'($urandom_range(0, 7));
         rd1 = $urandom;
         rd2 = ($urandom_range(0, 3) == 0) ? rd1 : $urandom;
         imm = $urandom; pc = $urandom; pcPlus4 = pc + 32'd4; rd = 5'($urandom);
         fwdA = 2'($urandom); fwdB = 2'($urandom); resultW = $urandom; aluResultFwd = $urandom;
         {regWrite, memWrite, resultSrc, branch, aluSrc} = 5'($urandom);
         injEn = 1'($urandom); injPersist = ($urandom_range(0, 3) == 0); injPass = 2'($urandom);
         injMask = ($urandom_range(0, 1) == 1) ? (32'd1 << $urandom_range(0, 31)) : $urandom;
         fltClr = ($urandom_range(0, 15) == 0);
         send($urandom_range(0, 7) == 0, 1);
      end

      // reset in the middle of execution
      setDefaults(); rd1 = 32'd3; rd2 = 32'd4; injEn = 1'b1; injPersist = 1'b1; injPass = 2'd1; injMask = 32'd2;
      send(0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkZero("midreset");
      q2.delete(); q3.delete();
      fd2 = 0; fd3 = 0;
      fcM[0] = 0; fcM[1] = 0; uncM[0] = 1'b0; uncM[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      setDefaults(); rd1 = 32'd9; rd2 = 32'd9; rd = 5'd7;
      send(0, 1);
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
